// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command wrapper.
package cmd_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd2_000_000;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'hEE;

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// 8-bit 8N1 transceiver UART; BAUD_DIV clk cycles per bit, receive sampled mid-bit.
module uart_cmd_wrapper_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);

    logic        tx_busy;
    logic [9:0]  tx_shift;
    logic [15:0] tx_baud;
    logic [3:0]  tx_bits;

    logic        rx_meta, rx_s, rx_busy;
    logic [7:0]  rx_shift;
    logic [15:0] rx_baud;
    logic [3:0]  rx_bits;

    assign TX = tx_shift[0];

    // Ones shift in behind the frame, so the line rests high once the stop bit is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_baud  <= '0;
            tx_bits  <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (trmt) begin
                    tx_shift <= {1'b1, tx_data, 1'b0};
                    tx_busy  <= 1'b1;
                    tx_baud  <= '0;
                    tx_bits  <= '0;
                end
            end else if (tx_baud == BAUD_LAST) begin
                tx_baud  <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // Sample 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_baud <= '0;
            rx_bits <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_baud <= BAUD_HALF;
                    rx_bits <= '0;
                    rx_rdy  <= 1'b0;
                end
            end else if (rx_baud == 16'd0) begin
                rx_baud <= BAUD_LAST;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_rdy  <= 1'b1;
                end else begin
                    rx_bits <= rx_bits + 4'd1;
                end
            end else begin
                rx_baud <= rx_baud - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_busy && rx_baud == 16'd0) begin
            if (rx_bits == 4'd9)
                rx_data <= rx_shift;
            else if (rx_bits != 4'd0)
                rx_shift <= {rx_s, rx_shift[7:1]};
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles 16-bit commands from two received bytes and transmits response bytes.
// Define CMD_TIMEOUT_EN to enable the inter-byte timeout and the frame_err pulse.
module uart_cmd_wrapper
    import cmd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int          BAUD_DIV    = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        frame_err
);

    rx_state_t   rx_state, rx_nxt;
    tx_state_t   tx_state, tx_nxt;
    logic [7:0]  high_byte, rx_data;
    logic        rx_rdy, clr_rx_rdy, trmt, tx_done;
    logic        latch_high, load_cmd, timeout, timeout_hit;
    logic        set_sent, clr_sent;

    uart_cmd_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .tx_data    (resp),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy)
    );

`ifdef CMD_TIMEOUT_EN
    logic [23:0] tmo_cnt;

    assign timeout_hit = (tmo_cnt == TIMEOUT_CYC - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout;
            if (latch_high)
                tmo_cnt <= '0;
            else if (rx_state == WAIT_LOW && tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 24'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_err   = 1'b0;
`endif

    // A low byte always beats a timeout landing in the same cycle.
    always_comb begin
        rx_nxt     = rx_state;
        clr_rx_rdy = 1'b0;
        latch_high = 1'b0;
        load_cmd   = 1'b0;
        timeout    = 1'b0;
        case (rx_state)
            IDLE: if (rx_rdy) begin
                latch_high = 1'b1;
                clr_rx_rdy = 1'b1;
                rx_nxt     = WAIT_LOW;
            end
            WAIT_LOW: if (rx_rdy) begin
                load_cmd   = 1'b1;
                clr_rx_rdy = 1'b1;
                rx_nxt     = IDLE;
            end else if (timeout_hit) begin
                timeout = 1'b1;
                rx_nxt  = IDLE;
            end
            default: rx_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            rx_state <= rx_nxt;
            if (load_cmd)
                cmd <= {high_byte, rx_data};
            if (load_cmd)
                cmd_rdy <= 1'b1;
            else if (latch_high || clr_cmd_rdy)
                cmd_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_high)
            high_byte <= rx_data;
    end

    always_comb begin
        tx_nxt   = tx_state;
        trmt     = 1'b0;
        set_sent = 1'b0;
        clr_sent = 1'b0;
        case (tx_state)
            TX_IDLE: if (send_resp) begin
                trmt     = 1'b1;
                clr_sent = 1'b1;
                tx_nxt   = TX_BUSY;
            end
            TX_BUSY: if (tx_done) begin
                set_sent = 1'b1;
                tx_nxt   = TX_IDLE;
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            resp_sent <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            if (set_sent)
                resp_sent <= 1'b1;
            else if (clr_sent)
                resp_sent <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: serial byte driver, TX frame decoder, byte-level command model.
module tb_uart_cmd_wrapper;
    import cmd_pkg::*;

    localparam int          BAUD = 16;
    localparam logic [23:0] TMO  = 24'd1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    uart_cmd_wrapper #(.TIMEOUT_CYC(TMO), .BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Byte-level model: each received byte either opens a command or completes it;
    // an open command older than TMO cycles is dropped with a frame_err pulse.
    logic [7:0]  sent_q[$];
    logic [15:0] m_cmd;
    logic        m_rdy, m_fe, m_have;
    logic [7:0]  m_high, m_b;
    int          m_age, cyc, t_byte;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd = 16'h0000; m_rdy = 1'b0; m_fe = 1'b0; m_have = 1'b0; m_age = 0;
            sent_q.delete();
        end else begin
            cyc++;
            m_fe = 1'b0;
            if (dut.u_uart.rx_rdy === 1'b1) begin
                t_byte = cyc;
                if (sent_q.size() == 0) begin
                    m_b = 8'hxx;
                    chk("byte_without_send", 32'd1, 32'd0);
                end else begin
                    m_b = sent_q.pop_front();
                end
                if (!m_have) begin
                    m_high = m_b; m_have = 1'b1; m_rdy = 1'b0; m_age = 0;
                end else begin
                    m_cmd = {m_high, m_b}; m_rdy = 1'b1; m_have = 1'b0;
                end
            end else begin
                if (clr_cmd_rdy) m_rdy = 1'b0;
                if (m_have) begin
                    m_age++;
`ifdef CMD_TIMEOUT_EN
                    if (m_age == int'(TMO)) begin
                        m_fe = 1'b1; m_have = 1'b0;
                    end
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("cmd", 32'(cmd), 32'(m_cmd));
                chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
                chk("frame_err", 32'(frame_err), 32'(m_fe));
            end
        end
    end

    // TX frame decoder, samples mid-bit on the falling clock edge.
    logic [7:0] tx_q[$];
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge TX);
            if (rst_n) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                chk("tx_stop_bit", 32'(TX), 32'd1);
                tx_q.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        sent_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_send(input logic [7:0] r);
        @(negedge clk); resp = r; send_resp = 1'b1;
        @(negedge clk); send_resp = 1'b0;
    endtask

    task automatic wait_sent(input string name);
        int n;
        n = 0;
        while (resp_sent !== 1'b1 && n < 400) begin
            @(negedge clk); n++;
        end
        chk(name, 32'(resp_sent), 32'd1);
    endtask

    task automatic reset_dut();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_resp_sent", 32'(resp_sent), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_tx_idle", 32'(TX), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        reset_dut();

        // 0x12, 0x34 -> 0x1234, held until acknowledged
        send_byte(8'h12); send_byte(8'h34);
        repeat (2) @(negedge clk);
        chk("cmd_1234", 32'(cmd), 32'h1234);
        chk("rdy_1234", 32'(cmd_rdy), 32'd1);
        repeat (50) @(negedge clk);
        chk("rdy_hold", 32'(cmd_rdy), 32'd1);
        pulse_clr();
        chk("rdy_cleared", 32'(cmd_rdy), 32'd0);
        chk("cmd_after_clr", 32'(cmd), 32'h1234);

`ifdef CMD_TIMEOUT_EN
        send_byte(8'hAB);
        n = 0;
        while (frame_err !== 1'b1 && n < 1200) begin
            @(posedge clk); #1; n++;
        end
        chk("frame_err_seen", 32'(frame_err), 32'd1);
        chk("frame_err_delay", 32'(cyc - t_byte), 32'd1000);
        chk("cmd_after_tmo", 32'(cmd), 32'h1234);
        send_byte(8'h56); send_byte(8'h78);
        repeat (2) @(negedge clk);
        chk("cmd_5678", 32'(cmd), 32'h5678);
        chk("rdy_5678", 32'(cmd_rdy), 32'd1);
`else
        send_byte(8'hAB);
        repeat (1100) @(negedge clk);
        chk("no_tmo_cmd", 32'(cmd), 32'h1234);
        send_byte(8'h56);
        repeat (2) @(negedge clk);
        chk("cmd_ab56", 32'(cmd), 32'hAB56);
`endif

        // response A5 with a second request mid-frame that must be ignored
        pulse_send(POS_ACK);
        repeat (2) @(negedge clk);
        chk("sent_cleared", 32'(resp_sent), 32'd0);
        repeat (5 * BAUD) @(negedge clk);
        pulse_send(NEG_ACK);
        wait_sent("resp_sent_a5");
        repeat (3 * BAUD) @(negedge clk);
        chk("tx_count_a5", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("tx_byte_a5", 32'(tx_q.pop_front()), 32'hA5);
        tx_q.delete();

        // back-to-back 0x0001, 0xFFFF without acknowledge
        send_byte(8'h00); send_byte(8'h01);
        repeat (2) @(negedge clk);
        chk("cmd_0001", 32'(cmd), 32'h0001);
        send_byte(8'hFF);
        chk("rdy_drop_b2b", 32'(cmd_rdy), 32'd0);
        chk("cmd_stable_b2b", 32'(cmd), 32'h0001);
        send_byte(8'hFF);
        repeat (2) @(negedge clk);
        chk("cmd_ffff", 32'(cmd), 32'hFFFF);
        chk("rdy_ffff", 32'(cmd_rdy), 32'd1);

        // reset after a lone high byte
        send_byte(8'h9C);
        reset_dut();
        send_byte(8'h01); send_byte(8'h02);
        repeat (2) @(negedge clk);
        chk("cmd_0102", 32'(cmd), 32'h0102);

        // full duplex
        pulse_clr();
        fork
            begin send_byte(8'hBE); send_byte(8'hEF); end
            begin repeat (20) @(negedge clk); pulse_send(NEG_ACK); end
        join
        repeat (2) @(negedge clk);
        chk("cmd_beef", 32'(cmd), 32'hBEEF);
        wait_sent("resp_sent_ee");
        repeat (3 * BAUD) @(negedge clk);
        chk("tx_count_ee", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("tx_byte_ee", 32'(tx_q.pop_front()), 32'hEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=running required=done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
